// File: rtl/serial_addsub_ctrl_if.sv
// Handshake, operand/result bus and external conditional-inverter link for serial_addsub_ctrl.
// The master side is the requester that also hosts the inverter (O = Y xor Mode).
interface serial_addsub_ctrl_if #(parameter int N = 4);
    logic         start;
    logic         mode;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         ci_mode;
    logic         ci_y;
    logic         ci_o;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         cout;
    logic         ovf;

    modport master (
        output start, mode, a, b, ci_o,
        input  ci_mode, ci_y, busy, done, result, cout, ovf
    );

    modport slave (
        input  start, mode, a, b, ci_o,
        output ci_mode, ci_y, busy, done, result, cout, ovf
    );
endinterface

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial N-bit add/subtract sequencer: streams B through an external inverter LSB first,
// does the full add internally and registers result, carry-out and signed overflow.
module serial_addsub_ctrl #(
    parameter int N = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    serial_addsub_ctrl_if.slave bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         r_state;
    state_t         w_nextState;
    logic [N-1:0]   r_aSh;
    logic [N-1:0]   r_bSh;
    logic [N-1:0]   r_sumSh;
    logic [N-1:0]   r_result;
    logic           r_mode;
    logic           r_carry;
    logic           r_cout;
    logic           r_ovf;
    logic [CW-1:0]  r_cnt;

    logic           w_capture;
    logic           w_lastBit;
    logic           w_sum;
    logic           w_carryNext;
    logic [N-1:0]   w_sumNext;

    // The inverter output is combinational, so this bit's sum and carry resolve in the same cycle.
    always_comb begin
        w_capture   = bus.start && ((r_state == IDLE) || (r_state == DONE));
        w_lastBit   = (r_cnt == CW'(N - 1));
        w_sum       = r_aSh[0] ^ bus.ci_o ^ r_carry;
        w_carryNext = (r_aSh[0] & bus.ci_o) | (r_aSh[0] & r_carry) | (bus.ci_o & r_carry);
        w_sumNext   = {w_sum, r_sumSh[N-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aSh    <= '0;
            r_bSh    <= '0;
            r_sumSh  <= '0;
            r_result <= '0;
            r_mode   <= 1'b0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_cnt    <= '0;
        end else if (w_capture) begin
            // Carry-in equals the mode bit: with B inverted this forms the +1 of two's complement.
            r_aSh   <= bus.a;
            r_bSh   <= bus.b;
            r_mode  <= bus.mode;
            r_carry <= bus.mode;
            r_sumSh <= '0;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_carry <= w_carryNext;
            r_sumSh <= w_sumNext;
            r_aSh   <= {1'b0, r_aSh[N-1:1]};
            r_bSh   <= {1'b0, r_bSh[N-1:1]};
            r_cnt   <= r_cnt + CW'(1);
            if (w_lastBit) begin
                r_result <= w_sumNext;
                r_cout   <= w_carryNext;
                r_ovf    <= r_carry ^ w_carryNext;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE:    w_nextState = bus.start ? RUN : IDLE;
            RUN:     w_nextState = w_lastBit ? DONE : RUN;
            DONE:    w_nextState = bus.start ? RUN : IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        bus.busy    = (r_state == RUN);
        bus.done    = (r_state == DONE);
        bus.ci_mode = (r_state == RUN) ? r_mode   : 1'b0;
        bus.ci_y    = (r_state == RUN) ? r_bSh[0] : 1'b0;
        bus.result  = r_result;
        bus.cout    = r_cout;
        bus.ovf     = r_ovf;
    end
endmodule

// File: doc/serial_addsub_ctrl.md
Name: serial_addsub_ctrl

Overview:
- Bit-serial add/subtract sequencer for an N-bit two's-complement operation.
- Time-shares one external conditional inverter (O = Y xor Mode): one operand-B bit per cycle, LSB first.
- Performs the 1-bit full add internally, with carry-in initialised to the mode bit.
- Start/busy/done handshake; registered result, carry-out and overflow flags.

Parameters:
- N, 4, operand/result width in bits (N >= 2).
- CW, $clog2(N), bit-counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- mode  input  1  0 = A+B, 1 = A-B; captured with start
- a  input  N  operand A; captured with start
- b  input  N  operand B; captured with start
- ci_mode  output  1  to inverter Mode; = captured mode in RUN, 0 otherwise
- ci_y  output  1  to inverter Y; = current B shift-register LSB in RUN, 0 otherwise
- ci_o  input  1  from inverter O; combinational, used same cycle
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse in DONE
- result  output  N  registered sum/difference
- cout  output  1  carry out of MSB; for subtract, 1 = no borrow
- ovf  output  1  signed overflow = carry into MSB xor carry out

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, result=0, cout=0, ovf=0, ci_mode=0, ci_y=0.
  - Internal shift registers, carry and counter cleared.
  - Takes effect immediately, including mid-RUN; the partial operation is discarded and no done is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge -> capture a, b, mode; carry<=mode; cnt<=0; next RUN.
  - start=0 -> stay IDLE.
- RUN (busy=1):
  - Combinational: ci_y=b_sh[0], ci_mode=mode_r, s = a_sh[0] xor ci_o xor carry.
  - Each edge: carry <= majority(a_sh[0], ci_o, carry); s shifts into MSB of sum_sh; a_sh and b_sh shift right; cnt++.
  - Bit k is processed at edge k+1 after the start edge.
  - At the edge where cnt==N-1:
    - result<=final sum_sh value, including this edge's s.
    - cout<=new carry.
    - ovf<=carry_in_to_MSB xor new carry, where carry_in_to_MSB is the carry register value before this edge.
    - next DONE.
  - start during RUN is ignored: no capture, no effect on the operation.
- DONE (done=1, busy=0, exactly one cycle):
  - start=1 -> capture new operands, next RUN (back-to-back).
  - start=0 -> next IDLE.
- Latency: done is high during the cycle following the Nth edge after the start edge.
  - N=4: start sampled at edge E0, done high between E4 and E5.
  - Throughput: one operation per N+1 cycles.
- result/cout/ovf change only on the edge entering DONE (or reset); held stable until the next completion.
- Arithmetic is modulo 2^N; no saturation.
- Operand or mode changes after capture have no effect.

Test Plan:
- N=4, mode=0, a=0101, b=0011, start 1 cycle -> busy 4 cycles; done pulse at E4-E5; result=1000, cout=0, ovf=1; ci_y sequence 1,1,0,0 and ci_mode=0 during RUN.
- mode=1, a=0101, b=0011 -> result=0010, cout=1, ovf=0; ci_mode=1 throughout RUN, 0 in IDLE.
- mode=1, a=0011, b=0101 -> result=1110, cout=0, ovf=0. Then mode=1, a=1000, b=0001 -> result=0111, cout=1, ovf=1.
- start (a=0001, b=0001, mode=0); during RUN pulse start with a=1111, b=1111 -> ignored; result=0010, single done pulse.
- Start an op, assert rst_n=0 after 2 RUN cycles -> busy, done, result, cout, ovf = 0 immediately; after release, no done until a new start; next op 0110+0001 gives 0111.
- start held high continuously with a=0001, b=0010, mode=0 -> done every 5 cycles, busy low only in DONE cycles; result=0011 each time.
